// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO behind a one-hot processor port interface
// Define UART_RX_FIFO_ERR_STORE_EN to keep perr/ferr/oerr per entry instead of sticky flags.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int DATA_IDX = 0,
  parameter int STAT_IDX = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        perr,
  input  logic        ferr,
  input  logic        oerr,
  input  logic [15:0] port_id,
  input  logic [15:0] reads,
  output logic        rx_ack,
  output logic [7:0]  out_port,
  output logic        not_empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
`ifdef UART_RX_FIFO_ERR_STORE_EN
  localparam int EW = 11;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {IDLE, PUSH, WAIT_LOW} state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovr;
  logic [2:0]    head_err;
  logic [7:0]    head_byte;
  logic [7:0]    status;
  logic          push;
  logic          pop;
  logic          do_write;
  logic          drop;
  logic          stat_rd;
  logic          unused_sel;

  assign push      = (state == PUSH);
  assign pop       = reads[DATA_IDX] && not_empty;
  // A simultaneous pop frees the slot the write pointer lands on, so a full FIFO still accepts.
  assign do_write  = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign stat_rd   = reads[STAT_IDX];
  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign unused_sel = ^{port_id, reads};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rx_ack <= 1'b0;
    end else begin
      rx_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            state  <= PUSH;
            rx_ack <= 1'b1;
          end
        end
        PUSH:     state <= WAIT_LOW;
        WAIT_LOW: if (!rx_rdy) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !pop)      count <= count + 1'b1;
      else if (pop && !do_write) count <= count - 1'b1;
      if (drop)         ovr <= 1'b1;
      else if (stat_rd) ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_entry;
  end

  assign head_entry = mem[rd_ptr];
  assign head_byte  = head_entry[EW-1:EW-8];

`ifdef UART_RX_FIFO_ERR_STORE_EN
  assign wr_entry = {rx_data, perr, ferr, oerr};
  assign head_err = not_empty ? head_entry[2:0] : 3'b000;
`else
  logic [2:0] err_sticky;
  logic [2:0] new_err;

  assign wr_entry = rx_data;
  assign new_err  = do_write ? {perr, ferr, oerr} : 3'b000;
  assign head_err = err_sticky;

  // Errors pushed in the same cycle as a status read survive the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_sticky <= 3'b000;
    else if (stat_rd) err_sticky <= new_err;
    else              err_sticky <= err_sticky | new_err;
  end
`endif

  assign status = {3'b000, ovr, head_err, not_empty};

  always_comb begin
    out_port = 8'h00;
    if (port_id[DATA_IDX])      out_port = head_byte;
    else if (port_id[STAT_IDX]) out_port = status;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (DEPTH=16)
module tb_uart_rx_fifo;

  localparam int DI = 0;
  localparam int SI = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        perr = 1'b0;
  logic        ferr = 1'b0;
  logic        oerr = 1'b0;
  logic [15:0] port_id = 16'h0000;
  logic [15:0] reads = 16'h0000;
  logic        rx_ack;
  logic [7:0]  out_port;
  logic        not_empty;
  logic        full;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_data[$];
  logic [7:0] exp_stat[$];
  bit         acked;
  logic       ne_at_ack;
  logic       ne_after;
  logic       ack_after;
  int         ack_cnt;

  uart_rx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .perr      (perr),
    .ferr      (ferr),
    .oerr      (oerr),
    .port_id   (port_id),
    .reads     (reads),
    .rx_ack    (rx_ack),
    .out_port  (out_port),
    .not_empty (not_empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare out_port on every read strobe against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (reads[DI] && port_id[DI]) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_unexpected: data read got %h with no expected byte", out_port);
        end else begin
          check_eq("data_read", out_port, exp_data.pop_front());
        end
      end
      if (reads[SI] && port_id[SI]) begin
        if (exp_stat.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stat_unexpected: status read got %h with no expected value", out_port);
        end else begin
          check_eq("status_read", out_port, exp_stat.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic p, input logic f, input logic o,
                           input bit pop_in_push);
    rx_data = d;
    perr = p;
    ferr = f;
    oerr = o;
    rx_rdy = 1'b1;
    acked = 1'b0;
    ne_at_ack = 1'b0;
    for (int i = 0; i < 8 && !acked; i++) begin
      tick();
      if (rx_ack) begin
        acked = 1'b1;
        ne_at_ack = not_empty;
      end
    end
    if (!acked) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no rx_ack for byte %h", d);
    end
    rx_rdy = 1'b0;
    if (pop_in_push) begin
      port_id[DI] = 1'b1;
      reads[DI] = 1'b1;
    end
    tick();
    ne_after = not_empty;
    ack_after = rx_ack;
    port_id = 16'h0000;
    reads = 16'h0000;
    tick();
    perr = 1'b0;
    ferr = 1'b0;
    oerr = 1'b0;
  endtask

  task automatic read_port(input int idx);
    port_id = 16'h0001 << idx;
    reads = 16'h0001 << idx;
    tick();
    port_id = 16'h0000;
    reads = 16'h0000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rx_ack", rx_ack, 0);
    check_eq("rst_not_empty", not_empty, 0);
    check_eq("rst_full", full, 0);
    check_eq("idle_out_port", out_port, 8'h00);
    reset = 1'b1;
    tick();

    // Single byte, latency and one-cycle ack
    send_byte(8'hA5, 0, 0, 0, 0);
    check_eq("a5_acked", acked, 1);
    check_eq("a5_ne_in_push", ne_at_ack, 0);
    check_eq("a5_ne_latency", ne_after, 1);
    check_eq("a5_ack_one_cycle", ack_after, 0);
    exp_stat.push_back(8'h01);
    read_port(SI);
    exp_data.push_back(8'hA5);
    read_port(DI);
    check_eq("a5_ne_after_pop", not_empty, 0);

    // Data read strobe while empty is ignored
    reads[DI] = 1'b1;
    tick();
    reads = 16'h0000;
    check_eq("empty_read_ne", not_empty, 0);
    check_eq("empty_read_full", full, 0);

    // Order, full flag and pointer wrap
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_eq("not_full_at_15", full, 0);
      send_byte(8'(i), 0, 0, 0, 0);
    end
    check_eq("full_at_16", full, 1);
    for (int i = 0; i < 16; i++) begin
      exp_data.push_back(8'(i));
      read_port(DI);
    end
    check_eq("drained_ne", not_empty, 0);
    send_byte(8'h55, 0, 0, 0, 0);
    exp_data.push_back(8'h55);
    read_port(DI);

    // Overflow drop
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 0, 0, 0, 0);
    check_eq("ovr_prefull", full, 1);
    send_byte(8'hEE, 0, 0, 0, 0);
    check_eq("ovr_acked", acked, 1);
    check_eq("ovr_still_full", full, 1);
    exp_stat.push_back(8'h11);
    read_port(SI);
    exp_stat.push_back(8'h01);
    read_port(SI);
    exp_data.push_back(8'h10);
    read_port(DI);
    check_eq("ovr_after_pop_full", full, 0);

    // Push and pop in the same cycle while full
    send_byte(8'h20, 0, 0, 0, 0);
    check_eq("sim_prefull", full, 1);
    exp_data.push_back(8'h11);
    send_byte(8'h77, 0, 0, 0, 1);
    check_eq("sim_count16", full, 1);
    exp_stat.push_back(8'h01);
    read_port(SI);
    for (int i = 8'h12; i <= 8'h20; i++) begin
      exp_data.push_back(8'(i));
      read_port(DI);
    end
    exp_data.push_back(8'h77);
    read_port(DI);
    check_eq("sim_drained", not_empty, 0);

    // Error flags
    send_byte(8'h3C, 1, 0, 0, 0);
`ifdef UART_RX_FIFO_ERR_STORE_EN
    exp_stat.push_back(8'h09);
    read_port(SI);
    exp_data.push_back(8'h3C);
    read_port(DI);
    exp_stat.push_back(8'h00);
    read_port(SI);
`else
    exp_data.push_back(8'h3C);
    read_port(DI);
    exp_stat.push_back(8'h08);
    read_port(SI);
    exp_stat.push_back(8'h00);
    read_port(SI);
`endif
    send_byte(8'h5A, 0, 1, 1, 0);
    exp_stat.push_back(8'h07);
    read_port(SI);
    exp_data.push_back(8'h5A);
    read_port(DI);
    exp_stat.push_back(8'h00);
    read_port(SI);

    // Reset during PUSH, then recapture once
    rx_data = 8'h99;
    rx_rdy = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 8 && !acked; i++) begin
      tick();
      if (rx_ack) acked = 1'b1;
    end
    check_eq("mr_acked", acked, 1);
    reset = 1'b0;
    #1;
    check_eq("mr_rx_ack", rx_ack, 0);
    check_eq("mr_not_empty", not_empty, 0);
    repeat (2) tick();
    reset = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rx_ack) begin
        ack_cnt++;
        rx_rdy = 1'b0;
      end
    end
    check_eq("mr_ack_once", 8'(ack_cnt), 1);
    check_eq("mr_captured", not_empty, 1);
    exp_data.push_back(8'h99);
    read_port(DI);
    check_eq("mr_single_entry", not_empty, 0);

    tick();
    check_eq("data_q_drained", 8'(exp_data.size()), 0);
    check_eq("stat_q_drained", 8'(exp_stat.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
